// File: rtl/static_cell_storage.sv
// static_cell_storage: playfield store, movement arbiter, line clearing and renderer read port
module static_cell_storage #(
    parameter int H_CELLS = 20,
    parameter int V_CELLS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       movement_request,
    input  logic       movement_intent,
    input  logic [4:0] P1blk_v,
    input  logic [4:0] P1blk_h,
    input  logic [4:0] P2blk_v,
    input  logic [4:0] P2blk_h,
    input  logic [4:0] P3blk_v,
    input  logic [4:0] P3blk_h,
    input  logic [4:0] P4blk_v,
    input  logic [4:0] P4blk_h,
    input  logic [2:0] volatile_blk_color,
    output logic       movement_commit,
    output logic       movement_declined,
    output logic       movement_steal,
    input  logic [4:0] rd_h,
    input  logic [4:0] rd_v,
    output logic [2:0] rd_color,
    output logic [7:0] lines_cleared,
    output logic       game_over,
    output logic       busy
);
    localparam int HW = $clog2(H_CELLS);
    localparam int VW = $clog2(V_CELLS);
    localparam logic [4:0] HMAX = 5'(H_CELLS);
    localparam logic [4:0] VMAX = 5'(V_CELLS);

    typedef enum logic [2:0] {IDLE, WAIT_LOW, DECLINE, STEAL_WAIT, LOCK, SCAN, SHIFT} state_t;

    state_t state;
    logic [2:0] field [H_CELLS][V_CELLS];
    logic [3:0][4:0] ph, pv, lh, lv, kh;
    logic [4:0] r;
    logic collide, lock_bad, row_full;
    logic [2:0] wcol;

    // Out-of-range coordinates (including wrapped underflow) count as occupied
    function automatic logic occ(input logic [4:0] h, input logic [4:0] v);
        return (h >= HMAX || v >= VMAX) || field[h[HW-1:0]][v[VW-1:0]] != 3'd0;
    endfunction

    assign ph = {P4blk_h, P3blk_h, P2blk_h, P1blk_h};
    assign pv = {P4blk_v, P3blk_v, P2blk_v, P1blk_v};
    assign wcol = volatile_blk_color == 3'd0 ? 3'b101 : volatile_blk_color;
    assign busy = state != IDLE;

    always_comb begin
        collide = 1'b0;
        lock_bad = 1'b0;
        row_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            kh[i] = lh[i] - 5'd1;
            collide = collide | occ(ph[i], pv[i]);
            lock_bad = lock_bad | occ(kh[i], lv[i]);
        end
        for (int j = 0; j < V_CELLS; j++)
            row_full = row_full && field[r[HW-1:0]][j] != 3'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            movement_commit <= 1'b0;
            movement_declined <= 1'b0;
            movement_steal <= 1'b0;
            game_over <= 1'b0;
            lines_cleared <= 8'd0;
            rd_color <= 3'd0;
            r <= 5'd0;
            lh <= '0;
            lv <= '0;
            for (int i = 0; i < H_CELLS; i++)
                for (int j = 0; j < V_CELLS; j++)
                    field[i][j] <= 3'd0;
        end else begin
            movement_commit <= 1'b0;
            game_over <= 1'b0;
            rd_color <= (rd_h < HMAX && rd_v < VMAX) ? field[rd_h[HW-1:0]][rd_v[VW-1:0]] : 3'd0;
            case (state)
                IDLE: if (movement_request) begin
                    if (!collide) begin
                        movement_commit <= 1'b1;
                        state <= WAIT_LOW;
                    end else if (movement_intent) begin
                        movement_declined <= 1'b1;
                        state <= DECLINE;
                    end else begin
                        movement_steal <= 1'b1;
                        lh <= ph;
                        lv <= pv;
                        state <= STEAL_WAIT;
                    end
                end
                WAIT_LOW: if (!movement_request) state <= IDLE;
                DECLINE: if (!movement_request) begin
                    movement_declined <= 1'b0;
                    state <= IDLE;
                end
                STEAL_WAIT: if (!movement_request) state <= LOCK;
                LOCK: if (lock_bad) begin
                    for (int i = 0; i < H_CELLS; i++)
                        for (int j = 0; j < V_CELLS; j++)
                            field[i][j] <= 3'd0;
                    lines_cleared <= 8'd0;
                    game_over <= 1'b1;
                    movement_steal <= 1'b0;
                    state <= IDLE;
                end else begin
                    for (int i = 0; i < 4; i++)
                        field[kh[i][HW-1:0]][lv[i][VW-1:0]] <= wcol;
                    r <= 5'(H_CELLS - 1);
                    state <= SCAN;
                end
                SCAN: if (row_full) state <= SHIFT;
                else if (r == 5'd0) begin
                    movement_steal <= 1'b0;
                    state <= IDLE;
                end else r <= r - 5'd1;
                SHIFT: begin
                    for (int i = H_CELLS - 1; i > 0; i--)
                        if (5'(i) <= r)
                            for (int j = 0; j < V_CELLS; j++)
                                field[i][j] <= field[i-1][j];
                    for (int j = 0; j < V_CELLS; j++)
                        field[0][j] <= 3'd0;
                    lines_cleared <= lines_cleared + 8'd1;
                    state <= SCAN;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_static_cell_storage.sv
// tb_static_cell_storage: directed scoreboard bench for static_cell_storage
module tb_static_cell_storage;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic movement_request = 1'b0, movement_intent = 1'b0;
    logic [4:0] P1blk_v = '0, P1blk_h = '0, P2blk_v = '0, P2blk_h = '0;
    logic [4:0] P3blk_v = '0, P3blk_h = '0, P4blk_v = '0, P4blk_h = '0;
    logic [2:0] volatile_blk_color = '0;
    logic movement_commit, movement_declined, movement_steal, game_over, busy;
    logic [4:0] rd_h = '0, rd_v = '0;
    logic [2:0] rd_color;
    logic [7:0] lines_cleared;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    static_cell_storage dut (
        .clk(clk), .reset(reset),
        .movement_request(movement_request), .movement_intent(movement_intent),
        .P1blk_v(P1blk_v), .P1blk_h(P1blk_h), .P2blk_v(P2blk_v), .P2blk_h(P2blk_h),
        .P3blk_v(P3blk_v), .P3blk_h(P3blk_h), .P4blk_v(P4blk_v), .P4blk_h(P4blk_h),
        .volatile_blk_color(volatile_blk_color),
        .movement_commit(movement_commit), .movement_declined(movement_declined),
        .movement_steal(movement_steal), .rd_h(rd_h), .rd_v(rd_v), .rd_color(rd_color),
        .lines_cleared(lines_cleared), .game_over(game_over), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Response codes: 1 commit, 2 decline, 3 steal, 4 game_over
    task automatic observe(input int got);
        int e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL resp got %0d expected none", got);
        end else begin
            e = exp_q.pop_front();
            if (e != got) begin
                errors++;
                $display("FAIL resp got %0d expected %0d", got, e);
            end
        end
    endtask

    logic pd = 1'b0, ps = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            pd = 1'b0;
            ps = 1'b0;
        end else begin
            if (movement_commit) observe(1);
            if (movement_declined && !pd) observe(2);
            if (movement_steal && !ps) observe(3);
            if (game_over) observe(4);
            pd = movement_declined;
            ps = movement_steal;
        end
    end

    task automatic cells(input logic [4:0] ah, av, bh, bv, ch, cv, dh, dv);
        P1blk_h = ah; P1blk_v = av; P2blk_h = bh; P2blk_v = bv;
        P3blk_h = ch; P3blk_v = cv; P4blk_h = dh; P4blk_v = dv;
    endtask

    task automatic rd_chk(input string nm, input logic [4:0] h, input logic [4:0] v, input logic [2:0] exp);
        rd_h = h;
        rd_v = v;
        @(posedge clk); #1;
        chk(nm, rd_color, exp);
    endtask

    task automatic lock_piece(input string nm, input logic [2:0] col, input int len);
        int cnt = 0;
        exp_q.push_back(3);
        movement_intent = 1'b0;
        volatile_blk_color = col;
        movement_request = 1'b1;
        @(posedge clk); #1;
        movement_request = 1'b0;
        do begin
            @(posedge clk); #1;
            cnt++;
        end while (movement_steal && cnt < 100);
        chk(nm, cnt, len);
    endtask

    task automatic decline_case(input string nm);
        exp_q.push_back(2);
        movement_intent = 1'b1;
        movement_request = 1'b1;
        @(posedge clk); #1;
        chk({nm, "_dec"}, movement_declined, 1);
        @(posedge clk); #1;
        chk({nm, "_hold"}, movement_declined, 1);
        movement_request = 1'b0;
        @(posedge clk); #1;
        chk({nm, "_drop"}, movement_declined, 0);
        chk({nm, "_idle"}, busy, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_commit", movement_commit, 0);
        chk("rst_declined", movement_declined, 0);
        chk("rst_steal", movement_steal, 0);
        chk("rst_game_over", game_over, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rd_color", rd_color, 0);
        chk("rst_lines", lines_cleared, 0);
        reset = 1'b0;

        cells(5'd5, 5'd5, 5'd5, 5'd6, 5'd6, 5'd5, 5'd6, 5'd6);
        exp_q.push_back(1);
        movement_intent = 1'b1;
        movement_request = 1'b1;
        @(posedge clk); #1;
        movement_request = 1'b0;
        chk("commit_hi", movement_commit, 1);
        chk("commit_no_dec", movement_declined, 0);
        chk("commit_no_steal", movement_steal, 0);
        @(posedge clk); #1;
        chk("commit_width", movement_commit, 0);
        chk("commit_idle", busy, 0);

        cells(5'd20, 5'd4, 5'd20, 5'd5, 5'd20, 5'd6, 5'd20, 5'd7);
        lock_piece("steal_len_a", 3'd0, 22);
        chk("lines_after_a", lines_cleared, 0);
        rd_chk("subst_19_4", 5'd19, 5'd4, 3'b101);
        rd_chk("subst_19_7", 5'd19, 5'd7, 3'b101);
        rd_chk("empty_19_8", 5'd19, 5'd8, 3'd0);

        cells(5'd16, 5'd5, 5'd17, 5'd5, 5'd18, 5'd5, 5'd19, 5'd5);
        decline_case("occupied");
        rd_chk("unchanged_19_5", 5'd19, 5'd5, 3'b101);
        rd_chk("unchanged_18_5", 5'd18, 5'd5, 3'd0);
        cells(5'd5, 5'd31, 5'd5, 5'd0, 5'd6, 5'd0, 5'd6, 5'd1);
        decline_case("underflow");
        cells(5'd5, 5'd10, 5'd5, 5'd9, 5'd6, 5'd9, 5'd6, 5'd8);
        decline_case("v_oob");

        cells(5'd20, 5'd8, 5'd20, 5'd9, 5'd20, 5'd8, 5'd20, 5'd9);
        lock_piece("steal_len_b", 3'd2, 22);
        cells(5'd19, 5'd4, 5'd18, 5'd4, 5'd17, 5'd4, 5'd16, 5'd4);
        lock_piece("steal_len_stack", 3'd6, 22);
        rd_chk("stack_15_4", 5'd15, 5'd4, 3'd6);

        // Filling v=0..3 completes row 19: one shift plus the re-check of row 19
        cells(5'd20, 5'd0, 5'd20, 5'd1, 5'd20, 5'd2, 5'd20, 5'd3);
        lock_piece("steal_len_clear", 3'd1, 24);
        chk("lines_one", lines_cleared, 1);
        rd_chk("shift_19_0", 5'd19, 5'd0, 3'd0);
        rd_chk("shift_19_4", 5'd19, 5'd4, 3'd6);
        rd_chk("shift_19_9", 5'd19, 5'd9, 3'd0);
        rd_chk("shift_16_4", 5'd16, 5'd4, 3'd6);
        rd_chk("shift_15_4", 5'd15, 5'd4, 3'd0);
        rd_chk("row0_empty", 5'd0, 5'd4, 3'd0);
        rd_chk("rd_oob", 5'd25, 5'd4, 3'd0);

        cells(5'd17, 5'd4, 5'd17, 5'd4, 5'd17, 5'd4, 5'd17, 5'd4);
        exp_q.push_back(3);
        exp_q.push_back(4);
        movement_intent = 1'b0;
        movement_request = 1'b1;
        @(posedge clk); #1;
        movement_request = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("go_pulse", game_over, 1);
        chk("go_steal_drop", movement_steal, 0);
        @(posedge clk); #1;
        chk("go_width", game_over, 0);
        chk("go_lines", lines_cleared, 0);
        chk("go_idle", busy, 0);
        rd_chk("go_cleared_19_4", 5'd19, 5'd4, 3'd0);

        cells(5'd20, 5'd0, 5'd20, 5'd1, 5'd20, 5'd2, 5'd20, 5'd3);
        exp_q.push_back(3);
        movement_request = 1'b1;
        @(posedge clk); #1;
        movement_request = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("scan_busy", busy, 1);
        chk("scan_steal", movement_steal, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_steal", movement_steal, 0);
        chk("mid_rst_commit", movement_commit, 0);
        chk("mid_rst_declined", movement_declined, 0);
        chk("mid_rst_game_over", game_over, 0);
        chk("mid_rst_rd_color", rd_color, 0);
        reset = 1'b0;
        rd_chk("mid_rst_field", 5'd19, 5'd0, 3'd0);
        chk("queue_drain", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
